// File: rtl/digit_scan_pkg.sv
// Shared defaults and helpers for the multiplexed digit scanner.
package digit_scan_pkg;

    localparam int DEF_NUM_DIGITS = 4;
    localparam int DEF_DIGIT_W    = 4;
    localparam int DEF_DIV        = 100000;
    localparam int DEF_BLANK_CYC  = 16;
    localparam int MAX_DIGITS     = 16;

    // Decode a digit index into a one-hot select vector of the maximum width.
    function automatic logic [MAX_DIGITS-1:0] onehot_decode(input logic [3:0] idx);
        logic [MAX_DIGITS-1:0] r;
        r      = {MAX_DIGITS{1'b0}};
        r[idx] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Digit-period prescaler: counts 0..DIV-1 while enabled and pulses tick on the last count.
// With DIGIT_SCAN_BLANK_EN defined the running count is also exported for dead-time decoding.
module scan_prescaler
    import digit_scan_pkg::*;
#(
    parameter int DIV   = DEF_DIV,
    parameter int CNT_W = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
`ifdef DIGIT_SCAN_BLANK_EN
    output logic [CNT_W-1:0] cnt,
`endif
    output logic             tick
);

    logic [CNT_W-1:0] cnt_r;

    assign tick = en && (cnt_r == CNT_W'(DIV - 1));

`ifdef DIGIT_SCAN_BLANK_EN
    assign cnt = cnt_r;
`endif

    // Free-running period counter, frozen while disabled, wrapping on tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (en) begin
            if (tick) begin
                cnt_r <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/digit_scan_mux.sv
// Time-multiplexed display scanner: one-hot digit select plus the matching digit field.
// Optional anti-ghosting dead time at the start of each digit period: DIGIT_SCAN_BLANK_EN.
module digit_scan_mux
    import digit_scan_pkg::*;
#(
    parameter int NUM_DIGITS = DEF_NUM_DIGITS,
    parameter int DIGIT_W    = DEF_DIGIT_W,
    parameter int DIV        = DEF_DIV,
    parameter int BLANK_CYC  = DEF_BLANK_CYC
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] value,
    output logic [NUM_DIGITS-1:0]         sel,
    output logic [DIGIT_W-1:0]            digit,
    output logic                          frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    if (NUM_DIGITS < 1 || NUM_DIGITS > MAX_DIGITS || DIGIT_W < 1 || DIGIT_W > 8 ||
        DIV < 1 || DIV > (1 << 24) || BLANK_CYC < 0 || BLANK_CYC >= DIV) begin : g_param_check
        $error("digit_scan_mux: parameter out of legal range");
    end

    logic                          en_q;
    logic                          tick_s;
    logic                          frame_tick_s;
    logic                          blank_s;
    logic [IDX_W-1:0]              idx_r;
    logic [IDX_W-1:0]              idx_nxt_s;
    logic [NUM_DIGITS*DIGIT_W-1:0] shadow_r;
    logic [NUM_DIGITS*DIGIT_W-1:0] shadow_nxt_s;
    logic [MAX_DIGITS-1:0]         oh_s;
    logic [DIGIT_W-1:0]            digit_nxt_s;
`ifdef DIGIT_SCAN_BLANK_EN
    logic [CNT_W-1:0]              cnt_s;
    logic [CNT_W-1:0]              cnt_nxt_s;
`endif

    scan_prescaler #(
        .DIV   (DIV),
        .CNT_W (CNT_W)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en_q),
`ifdef DIGIT_SCAN_BLANK_EN
        .cnt   (cnt_s),
`endif
        .tick  (tick_s)
    );

    // Next-state of index and shadow; outputs are registered from these so they move with them.
    always_comb begin
        frame_tick_s = tick_s && (idx_r == IDX_W'(NUM_DIGITS - 1));
        if (frame_tick_s) begin
            idx_nxt_s = {IDX_W{1'b0}};
        end else if (tick_s) begin
            idx_nxt_s = idx_r + IDX_W'(1);
        end else begin
            idx_nxt_s = idx_r;
        end
        shadow_nxt_s = frame_tick_s ? value : shadow_r;
        oh_s         = onehot_decode(4'(idx_nxt_s));
        digit_nxt_s  = {DIGIT_W{1'b0}};
        for (int k = 0; k < NUM_DIGITS; k++) begin
            digit_nxt_s = digit_nxt_s |
                ({DIGIT_W{idx_nxt_s == IDX_W'(k)}} & shadow_nxt_s[k*DIGIT_W +: DIGIT_W]);
        end
`ifdef DIGIT_SCAN_BLANK_EN
        if (!en_q) begin
            cnt_nxt_s = cnt_s;
        end else if (tick_s) begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end else begin
            cnt_nxt_s = cnt_s + CNT_W'(1);
        end
        blank_s = (int'(cnt_nxt_s) < BLANK_CYC);
`else
        blank_s = 1'b0;
`endif
    end

    // Scan state and registered outputs; en takes effect on the outputs as en_q updates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q       <= 1'b0;
            idx_r      <= {IDX_W{1'b0}};
            shadow_r   <= {(NUM_DIGITS*DIGIT_W){1'b0}};
            sel        <= {NUM_DIGITS{1'b0}};
            digit      <= {DIGIT_W{1'b0}};
            frame_done <= 1'b0;
        end else begin
            en_q       <= en;
            idx_r      <= idx_nxt_s;
            shadow_r   <= shadow_nxt_s;
            sel        <= (en && !blank_s) ? oh_s[NUM_DIGITS-1:0] : {NUM_DIGITS{1'b0}};
            digit      <= en ? digit_nxt_s : {DIGIT_W{1'b0}};
            frame_done <= en && frame_tick_s;
        end
    end

endmodule

// File: tb/tb_digit_scan_mux.sv
// Directed bench: a 4-digit DIV=4 scanner and an 8-digit DIV=1 scanner.
module tb_digit_scan_mux;

`ifdef DIGIT_SCAN_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        en8 = 1'b0;
    logic [15:0] value = 16'h1234;
    logic [31:0] value8 = 32'h76543210;
    logic [3:0]  sel;
    logic [3:0]  digit;
    logic        frame_done;
    logic [7:0]  sel8;
    logic [3:0]  digit8;
    logic        frame_done8;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    digit_scan_mux #(.NUM_DIGITS(4), .DIGIT_W(4), .DIV(4), .BLANK_CYC(1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .value(value),
        .sel(sel), .digit(digit), .frame_done(frame_done));

    digit_scan_mux #(.NUM_DIGITS(8), .DIGIT_W(4), .DIV(1), .BLANK_CYC(0)) dut8 (
        .clk(clk), .rst_n(rst_n), .en(en8), .value(value8),
        .sel(sel8), .digit(digit8), .frame_done(frame_done8));

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total_cnt++;
        if (sel !== 4'b0000) $display("FAIL reset_sel got %b exp 0000", sel); else pass_cnt++;
        total_cnt++;
        if (digit !== 4'h0) $display("FAIL reset_digit got %h exp 0", digit); else pass_cnt++;
        total_cnt++;
        if (frame_done !== 1'b0) $display("FAIL reset_fd got %b exp 0", frame_done); else pass_cnt++;
    endtask

    // Four frames: zeros, 1234, 1234 (value changed mid-frame), then ABCD.
    task automatic test_scan();
        int cnt, idx, f;
        logic [15:0] shadow;
        logic [3:0]  exp_sel, exp_digit;
        logic        exp_fd;
        rst_n = 1'b1;
        en    = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            cnt = (k - 1) % 4;
            idx = ((k - 1) / 4) % 4;
            f   = (k - 1) / 16;
            shadow    = (f == 0) ? 16'h0000 : ((f <= 2) ? 16'h1234 : 16'hABCD);
            exp_digit = 4'((shadow >> (idx * 4)) & 16'h000F);
            exp_sel   = (BLANK && cnt < 1) ? 4'b0000 : (4'b0001 << idx);
            exp_fd    = (k > 1) && (k % 16 == 1);
            total_cnt++;
            if (sel !== exp_sel) $display("FAIL scan_sel k=%0d got %b exp %b", k, sel, exp_sel);
            else pass_cnt++;
            total_cnt++;
            if (digit !== exp_digit) $display("FAIL scan_digit k=%0d got %h exp %h", k, digit, exp_digit);
            else pass_cnt++;
            total_cnt++;
            if (frame_done !== exp_fd) $display("FAIL scan_fd k=%0d got %b exp %b", k, frame_done, exp_fd);
            else pass_cnt++;
            if (k == 38) value = 16'hABCD;
        end
    endtask

    // Drop en while cnt=1, idx=1 so the count freezes at 2; resume and watch idx advance.
    task automatic test_enable_hold();
        logic [3:0] exp_sel;
        repeat (6) @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total_cnt++;
            if (sel !== 4'b0000 || digit !== 4'h0 || frame_done !== 1'b0)
                $display("FAIL hold_blank i=%0d got sel=%b digit=%h fd=%b exp 0000/0/0",
                         i, sel, digit, frame_done);
            else pass_cnt++;
        end
        en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total_cnt++;
            if (sel !== 4'b0010 || digit !== 4'hC)
                $display("FAIL resume_idx1 i=%0d got sel=%b digit=%h exp 0010/c", i, sel, digit);
            else pass_cnt++;
        end
        @(negedge clk);
        exp_sel = BLANK ? 4'b0000 : 4'b0100;
        total_cnt++;
        if (sel !== exp_sel || digit !== 4'hB)
            $display("FAIL resume_idx2 got sel=%b digit=%h exp %b/b", sel, digit, exp_sel);
        else pass_cnt++;
    endtask

    // Reset asserted between clock edges; outputs must clear without waiting for clk.
    task automatic test_async_reset();
        logic [3:0] exp_digit;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (sel !== 4'b0000) $display("FAIL async_sel got %b exp 0000", sel); else pass_cnt++;
        total_cnt++;
        if (digit !== 4'h0) $display("FAIL async_digit got %h exp 0", digit); else pass_cnt++;
        total_cnt++;
        if (frame_done !== 1'b0) $display("FAIL async_fd got %b exp 0", frame_done); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            exp_digit = (k <= 16) ? 4'h0 : 4'hD;
            total_cnt++;
            if (digit !== exp_digit || frame_done !== (k == 17))
                $display("FAIL post_reset k=%0d got digit=%h fd=%b exp %h/%b",
                         k, digit, frame_done, exp_digit, (k == 17));
            else pass_cnt++;
        end
    endtask

    // DIV=1 with 8 digits: a new digit every enabled cycle, frame_done every 8.
    task automatic test_div1();
        logic [7:0] exp_sel;
        logic [3:0] exp_digit;
        logic       exp_fd;
        en8 = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            exp_sel   = 8'b0000_0001 << ((k - 1) % 8);
            exp_digit = (k <= 8) ? 4'h0 : 4'((k - 9) % 8);
            exp_fd    = (k == 9) || (k == 17);
            total_cnt++;
            if (sel8 !== exp_sel || digit8 !== exp_digit || frame_done8 !== exp_fd)
                $display("FAIL div1 k=%0d got sel=%b digit=%h fd=%b exp %b/%h/%b",
                         k, sel8, digit8, frame_done8, exp_sel, exp_digit, exp_fd);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_enable_hold();
        test_async_reset();
        test_div1();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
